// File: rtl/fp_operand_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp_operand_unpack
// Purpose  : Splits a packed IEEE-754 single-precision operand into sign,
//            widened two's-complement biased exponent and mantissa with the
//            hidden bit restored. Classifies zero/denormal/inf/qNaN/sNaN and
//            pre-normalizes denormals one left shift per cycle so downstream
//            alignment logic always sees a leading 1 for finite non-zeros.
// Ports    : clk, rst_n          - clock, async active-low reset
//            in_valid/in_ready   - operand handshake (ready only when idle)
//            in_operand          - {sign, exp, frac}
//            out_valid/out_ready - result handshake, outputs frozen until taken
//            sign_out, exp_out, mant_out, norm_shift - unpacked fields
//            is_zero, is_denorm, is_inf, is_nan, is_snan - class flags
// Revision : 1.0 - initial release
// ============================================================================
module fp_operand_unpack #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int OUT_EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_operand,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_out,
  output logic [OUT_EXP_W-1:0]    exp_out,
  output logic [FRAC_W:0]         mant_out,
  output logic [4:0]              norm_shift,
  output logic                    is_zero,
  output logic                    is_denorm,
  output logic                    is_inf,
  output logic                    is_nan,
  output logic                    is_snan
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [OUT_EXP_W-1:0] c_EXP_ONE = {{(OUT_EXP_W-1){1'b0}}, 1'b1};

  state_t                 r_state, w_state_nxt;
  logic                   r_sign,   w_sign_nxt;
  logic [OUT_EXP_W-1:0]   r_exp,    w_exp_nxt;
  logic [FRAC_W:0]        r_mant,   w_mant_nxt;
  logic [4:0]             r_shift,  w_shift_nxt;
  logic [4:0]             r_flags,  w_flags_nxt;   // {zero, denorm, inf, nan, snan}

  // Operand field split
  logic                   w_in_sign;
  logic [EXP_W-1:0]       w_in_exp;
  logic [FRAC_W-1:0]      w_in_frac;
  logic [OUT_EXP_W-1:0]   w_in_exp_ext;
  logic                   w_exp_max, w_exp_zero, w_frac_zero;
  logic [FRAC_W:0]        w_mant_sh;

  assign w_in_sign    = in_operand[EXP_W+FRAC_W];
  assign w_in_exp     = in_operand[EXP_W+FRAC_W-1 -: EXP_W];
  assign w_in_frac    = in_operand[FRAC_W-1:0];
  assign w_in_exp_ext = {{(OUT_EXP_W-EXP_W){1'b0}}, w_in_exp};
  assign w_exp_max    = &w_in_exp;
  assign w_exp_zero   = ~|w_in_exp;
  assign w_frac_zero  = ~|w_in_frac;
  assign w_mant_sh    = {r_mant[FRAC_W-1:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_shift <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_exp   <= w_exp_nxt;
      r_mant  <= w_mant_nxt;
      r_shift <= w_shift_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_mant_nxt  = r_mant;
    w_shift_nxt = r_shift;
    w_flags_nxt = r_flags;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = w_in_sign;
          w_shift_nxt = '0;
          w_state_nxt = HOLD;
          if (w_exp_max) begin
            // Inf and NaN both report the all-ones exponent; NaN payload is
            // passed through untouched behind the hidden bit.
            w_exp_nxt  = w_in_exp_ext;
            w_mant_nxt = {1'b1, w_in_frac};
            if (w_frac_zero) begin
              w_flags_nxt = 5'b00100;
            end else begin
              w_flags_nxt = {3'b000, 1'b1, ~w_in_frac[FRAC_W-1]};
            end
          end else if (w_exp_zero) begin
            if (w_frac_zero) begin
              w_exp_nxt   = '0;
              w_mant_nxt  = '0;
              w_flags_nxt = 5'b10000;
            end else begin
              // Denormals carry an effective exponent of 1 before shifting.
              w_exp_nxt   = c_EXP_ONE;
              w_mant_nxt  = {1'b0, w_in_frac};
              w_flags_nxt = 5'b01000;
              w_state_nxt = NORM;
            end
          end else begin
            w_exp_nxt   = w_in_exp_ext;
            w_mant_nxt  = {1'b1, w_in_frac};
            w_flags_nxt = 5'b00000;
          end
        end
      end
      NORM: begin
        w_mant_nxt  = w_mant_sh;
        w_exp_nxt   = r_exp - c_EXP_ONE;
        w_shift_nxt = r_shift + 5'd1;
        if (w_mant_sh[FRAC_W]) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == HOLD);
  assign sign_out   = r_sign;
  assign exp_out    = r_exp;
  assign mant_out   = r_mant;
  assign norm_shift = r_shift;
  assign is_zero    = r_flags[4];
  assign is_denorm  = r_flags[3];
  assign is_inf     = r_flags[2];
  assign is_nan     = r_flags[1];
  assign is_snan    = r_flags[0];

endmodule
`default_nettype wire

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
- Input-side counterpart of the result packer. Takes a packed IEEE-754 single-precision operand and splits it into sign, widened signed exponent, and 24-bit mantissa with the hidden bit restored.
- Classifies the operand (zero/denormal/inf/qNaN/sNaN) and iteratively pre-normalizes denormals, one left shift per cycle, so downstream datapaths see a leading 1.
- Sits between the operand registers and the adder/multiplier alignment stage, with valid/ready on both sides.

Parameters:
- EXP_W, 8, packed exponent field width.
- FRAC_W, 23, packed fraction field width.
- OUT_EXP_W, 10, width of the two's-complement output exponent; must be at least EXP_W+2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept; combinational, equals (state==IDLE).
- in_operand  in  32  packed {sign, exp[7:0], frac[22:0]}.
- out_valid  out  1  unpacked result valid.
- out_ready  in  1  consumer accepts the result.
- sign_out  out  1  operand sign.
- exp_out  out  OUT_EXP_W  signed biased exponent after normalization.
- mant_out  out  24  {hidden, frac} after normalization.
- norm_shift  out  5  left shifts applied (0..23).
- is_zero, is_denorm, is_inf, is_nan, is_snan  out  1 each  class flags; exactly one of zero/denorm/inf/nan or none (normal); is_snan implies is_nan.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except in_ready=1 (follows IDLE). Any operation in flight is discarded. No out_valid after release until a new accept.
- States are IDLE, NORM and HOLD.
- IDLE: on in_valid&&in_ready, register the operand and classify:
  - exp=FF, frac=0: inf. exp_out=255, mant_out=0x800000, goto HOLD.
  - exp=FF, frac≠0: nan. is_snan=~frac[22]. exp_out=255, mant_out={1,frac} unmodified, goto HOLD.
  - exp=0, frac=0: zero. exp_out=0, mant_out=0, goto HOLD. Sign is preserved (−0 keeps sign 1).
  - exp=0, frac≠0: denorm. mant={0,frac}, exp=1, norm_shift=0, goto NORM.
  - otherwise normal: mant={1,frac}, exp=E zero-extended, goto HOLD.
- NORM (once per cycle):
  - mant<<=1, exp-=1, norm_shift+=1.
  - If the shifted mant[23]==1, goto HOLD; otherwise stay.
  - Exponent arithmetic is in OUT_EXP_W-bit two's complement. The minimum result is 1−23=−22 (10'h3EA), so there is no wrap.
- HOLD: out_valid=1. All outputs stay stable while out_ready=0. On out_ready=1, goto IDLE and drop out_valid on the next edge.
- Latency: out_valid rises on the edge after accept for non-denormals. For a denormal whose highest set frac bit is p, it rises 1+(23−p) edges after accept.
- Throughput: at most one operand per two cycles. There is no accept while in NORM or HOLD (in_ready=0).
- in_operand is ignored when not accepted. in_valid may drop without handshake while in_ready=0.

Test Plan:
- 0x3FC00000 accepted, out_ready=1 → one edge later: sign 0, exp_out 127, mant 0xC00000, norm_shift 0, all flags 0; in_ready back to 1 on the following edge.
- 0x80400000 (denorm, p=22) → out_valid 2 edges after accept: sign 1, exp_out 0, mant 0x800000, norm_shift 1, is_denorm 1.
- 0x00000001 → out_valid 24 edges after accept: exp_out 10'h3EA (−22), mant 0x800000, norm_shift 23; in_ready 0 throughout.
- Specials:
  - 0x7F800000 → is_inf, exp_out 255, mant 0x800000.
  - 0x7FA00000 → is_nan, is_snan, mant 0xA00000.
  - 0xFFC00000 → is_nan only, sign 1.
  - 0x80000000 → is_zero, sign 1, mant 0.
- Backpressure: accept 0x40490FDB, hold out_ready=0 for 5 cycles → outputs frozen at exp 128, mant 0xC90FDB; in_ready 0; a second in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-NORM: accept 0x00000001, assert rst_n=0 on cycle 10 → outputs 0 immediately (async); after release in_ready=1, no spurious out_valid; next operand 0x3F800000 yields exp 127, mant 0x800000.
